// File: rtl/round_robin_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// RoundRobinArbiterTypes
//
// Shared types and helpers for the round-robin bus arbiter.
//   ArbiterState : IDLE (arbitrate), GRANTED (owner holds bus),
//                  RELEASE (one dead turnaround cycle)
//   index_width  : width of a device index, never narrower than 1 bit
// -----------------------------------------------------------------------------
package RoundRobinArbiterTypes;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } ArbiterState;

    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/round_robin_bus_arbiter_rotating_priority_encoder.sv
// -----------------------------------------------------------------------------
// rotating_priority_encoder
//
// Purely combinational. Finds the first set request bit scanning from ptr_i
// upward, wrapping modulo NUM_DEVICES.
//   requests_i : one bit per device
//   ptr_i      : index of the highest-priority device (always < NUM_DEVICES)
//   found_o    : at least one request is set
//   index_o    : selected device index, 0 when found_o is low
// -----------------------------------------------------------------------------
module rotating_priority_encoder
    import RoundRobinArbiterTypes::*;
#(
    parameter int NUM_DEVICES = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_DEVICES-1:0] requests_i,
    input  logic [INDEX_WIDTH-1:0] ptr_i,
    output logic                   found_o,
    output logic [INDEX_WIDTH-1:0] index_o
);

    // One extra bit so ptr + offset (at most 2*N-2) never overflows before the wrap.
    localparam int SumWidth = INDEX_WIDTH + 1;

    logic [SumWidth-1:0] candidate;

    // Scan from the farthest offset down to offset 0 so the closest requester
    // to ptr_i is the last one written and therefore wins.
    always_comb begin
        found_o   = 1'b0;
        index_o   = '0;
        candidate = '0;
        for (int k = NUM_DEVICES - 1; k >= 0; k--) begin
            candidate = {1'b0, ptr_i} + SumWidth'(k);
            if (candidate >= SumWidth'(NUM_DEVICES)) begin
                candidate = candidate - SumWidth'(NUM_DEVICES);
            end
            if (requests_i[candidate[INDEX_WIDTH-1:0]]) begin
                found_o = 1'b1;
                index_o = candidate[INDEX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/round_robin_bus_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_bus_arbiter
//
// Shares the snoopy-bus CPU-side path between per-device cache controllers.
// A granted cache owns the bus until it drops its request; a RELEASE cycle
// plus the IDLE arbitration edge separate consecutive owners.
//
// Request/grant handshake: requests[i] acts as a level "valid" that must stay
// high for as long as cache i wants the bus; grants[i] is the "ready" and,
// once raised, stays high until the arbiter samples requests[i]=0 (or a hold
// timeout revokes it). Dropping the request in the cycle the grant appears
// still yields one grant cycle.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-high
//   requests   : one request line per cache
//   grants     : registered one-hot grant (or zero)
//   grantIndex : index of current owner, 0 when no grant
//   busy       : high exactly when grants is non-zero
//   preempted  : one-cycle pulse when a grant is revoked by timeout
//
// Configuration macro: HOLD_TIMEOUT_EN
//   defined   : owner is preempted after MAX_HOLD_CYCLES owned cycles if any
//               other cache is waiting
//   undefined : grant is held indefinitely, preempted is tied to 0
//
// The FSM state register state_q is typed ArbiterState for observation.
// -----------------------------------------------------------------------------
module round_robin_bus_arbiter
    import RoundRobinArbiterTypes::*;
#(
    parameter int  NUMBER_OF_DEVICES = 4,
    parameter int  MAX_HOLD_CYCLES   = 16,
    localparam int IndexWidth        = index_width(NUMBER_OF_DEVICES)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUMBER_OF_DEVICES-1:0] requests,
    output logic [NUMBER_OF_DEVICES-1:0] grants,
    output logic [IndexWidth-1:0]        grantIndex,
    output logic                         busy,
    output logic                         preempted
);

    ArbiterState                  state_q;
    logic [NUMBER_OF_DEVICES-1:0] grants_q;
    logic [IndexWidth-1:0]        index_q;
    logic [IndexWidth-1:0]        ptr_q;
    logic                         busy_q;

    logic                         found_d;
    logic [IndexWidth-1:0]        select_index_d;
    logic [NUMBER_OF_DEVICES-1:0] select_onehot_d;
    logic [IndexWidth-1:0]        ptr_after_owner_d;

    rotating_priority_encoder #(
        .NUM_DEVICES (NUMBER_OF_DEVICES),
        .INDEX_WIDTH (IndexWidth)
    ) u_encoder (
        .requests_i (requests),
        .ptr_i      (ptr_q),
        .found_o    (found_d),
        .index_o    (select_index_d)
    );

    always_comb begin
        select_onehot_d                 = '0;
        select_onehot_d[select_index_d] = 1'b1;
    end

    // Priority moves to the device just after the releasing owner.
    always_comb begin
        if (index_q == IndexWidth'(NUMBER_OF_DEVICES - 1)) begin
            ptr_after_owner_d = '0;
        end else begin
            ptr_after_owner_d = index_q + IndexWidth'(1);
        end
    end

`ifdef HOLD_TIMEOUT_EN
    localparam int HoldWidth = $clog2(MAX_HOLD_CYCLES + 1);

    logic [HoldWidth-1:0] hold_q;
    logic                 preempted_q;
    logic                 others_waiting_d;

    assign others_waiting_d = |(requests & ~grants_q);
    assign preempted        = preempted_q;
`else
    assign preempted = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grants_q <= '0;
            index_q  <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_q      <= '0;
            preempted_q <= 1'b0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
            preempted_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grants_q <= select_onehot_d;
                        index_q  <= select_index_d;
                        busy_q   <= 1'b1;
                        state_q  <= GRANTED;
`ifdef HOLD_TIMEOUT_EN
                        hold_q   <= '0;
`endif
                    end
                end
                GRANTED: begin
                    if (!requests[index_q]) begin
                        grants_q <= '0;
                        index_q  <= '0;
                        busy_q   <= 1'b0;
                        ptr_q    <= ptr_after_owner_d;
                        state_q  <= RELEASE;
`ifdef HOLD_TIMEOUT_EN
                    end else if (hold_q == HoldWidth'(MAX_HOLD_CYCLES) && others_waiting_d) begin
                        // Owner still requesting but has used its budget while
                        // someone else waits: revoke exactly like a release.
                        grants_q    <= '0;
                        index_q     <= '0;
                        busy_q      <= 1'b0;
                        ptr_q       <= ptr_after_owner_d;
                        state_q     <= RELEASE;
                        preempted_q <= 1'b1;
                    end else if (hold_q != HoldWidth'(MAX_HOLD_CYCLES)) begin
                        hold_q <= hold_q + HoldWidth'(1);
`endif
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grants     = grants_q;
    assign grantIndex = index_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
module tb_round_robin_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;
  localparam int W    = 8;   // {preempted, busy, grantIndex[1:0], grants[3:0]}

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] requests = '0;
  logic [N-1:0] grants;
  logic [1:0]   grantIndex;
  logic         busy;
  logic         preempted;

  always #5 clock = ~clock;

  round_robin_bus_arbiter #(
    .NUMBER_OF_DEVICES (N),
    .MAX_HOLD_CYCLES   (MAXH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .requests   (requests),
    .grants     (grants),
    .grantIndex (grantIndex),
    .busy       (busy),
    .preempted  (preempted)
  );

  // ---------------- reference model ----------------
  // Owner as an integer (-1 = nobody), priority pointer, count of silent
  // cycles still owed after a release, and cycles owned so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_dead  = 0;
  int m_hold  = 0;
  bit m_pre   = 1'b0;

  function automatic logic [W-1:0] model_step(input logic rs, input logic [N-1:0] rq);
    logic [N-1:0] g;
    logic [1:0]   ix;
    logic [N-1:0] others;
    m_pre = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_dead  = 0;
      m_hold  = 0;
    end else if (m_owner >= 0) begin
      others = rq & ~(N'(1) << m_owner);
      if (!rq[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = 1;
`ifdef HOLD_TIMEOUT_EN
      end else if (m_hold == MAXH && others != 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = 1;
        m_pre   = 1'b1;
`endif
      end else if (m_hold < MAXH) begin
        m_hold++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rq[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_hold  = 0;
          break;
        end
      end
    end
    g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    ix = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    return {m_pre, (m_owner >= 0), ix, g};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           cycle_no    = 0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  always @(posedge clock) begin
    cycle_no <= cycle_no + 1;
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {preempted, busy, grantIndex, grants};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got pre=%b busy=%b idx=%0d grants=%b, expected pre=%b busy=%b idx=%0d grants=%b",
                 cycle_no, mon_act[7], mon_act[6], mon_act[5:4], mon_act[3:0],
                 mon_exp[7], mon_exp[6], mon_exp[5:4], mon_exp[3:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rs, input logic [N-1:0] rq);
    @(negedge clock);
    reset    = rs;
    requests = rq;
    @(posedge clock);
    exp_q.push_back(model_step(rs, rq));
  endtask

  task automatic drive_n(input logic rs, input logic [N-1:0] rq, input int n);
    for (int i = 0; i < n; i++) drive(rs, rq);
  endtask

  logic [N-1:0] rnd_req;

  initial begin
    // reset and quiet bus
    drive_n(1'b1, 4'b0000, 3);
    drive_n(1'b0, 4'b0000, 10);
    // device 1 wins from ptr=0, then device 3 after the turnaround
    drive_n(1'b0, 4'b1010, 4);
    drive_n(1'b0, 4'b1000, 6);
    // device 3 releases, pointer wraps to 0
    drive_n(1'b0, 4'b0000, 3);
    drive_n(1'b0, 4'b1001, 4);
    drive_n(1'b0, 4'b0000, 4);
    // reset in the middle of a grant
    drive_n(1'b0, 4'b0100, 3);
    drive(1'b1, 4'b0100);
    drive_n(1'b0, 4'b0100, 3);
    drive_n(1'b0, 4'b0110, 3);
    drive_n(1'b0, 4'b0000, 4);
    // drop request in the same cycle the grant appears
    drive(1'b0, 4'b0001);
    drive_n(1'b0, 4'b0000, 4);
    // long contention (preemption when timeout is built in)
    drive_n(1'b0, 4'b0011, 15);
    drive_n(1'b0, 4'b0000, 4);
    // sole requester holds the bus
    drive_n(1'b0, 4'b0001, 20);
    drive_n(1'b0, 4'b0000, 4);
    // randomized traffic: request bits toggle occasionally, rare resets
    rnd_req = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rnd_req[b] = ~rnd_req[b];
      end
      drive(($urandom_range(0, 299) == 0), rnd_req);
    end
    drive_n(1'b0, 4'b0000, 2);
    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
